// File: rtl/tc_pl_cap_spi_pkg.sv
// Shared types and default timing for the gain-ADC SPI transmitter.
// Holds the FSM state encoding and the default frame timing constants.
package tc_pl_cap_spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } spi_state_t;

    localparam int DEF_SPI0_0   = 8;
    localparam int DEF_CLK_DIV  = 4;
    localparam int DEF_CS_SETUP = 2;
    localparam int DEF_CS_HOLD  = 2;
    localparam int DEF_CS_GAP   = 4;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/tc_pl_cap_gain_spi_tx_if.sv
// Byte-stream handshake between the gain control path (master) and the
// SPI transmitter (slave).
interface tc_pl_cap_gain_spi_tx_if
    import tc_pl_cap_spi_pkg::*;
#(
    parameter int SPI0_0 = DEF_SPI0_0
);
    logic              stx_idle;
    logic              stx_dreq;
    logic              stx_valid;
    logic [SPI0_0-1:0] stx_data;

    modport master (
        input  stx_idle,
        input  stx_dreq,
        output stx_valid,
        output stx_data
    );

    modport slave (
        output stx_idle,
        output stx_dreq,
        input  stx_valid,
        input  stx_data
    );
endinterface

// File: rtl/tc_pl_cap_spi_clkgen.sv
// SCLK generator: toggles sclk every CLK_DIV enabled cycles, starting low,
// and flags the cycle on which the next rise or fall takes effect.
module tc_pl_cap_spi_clkgen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic sclk,
    output logic sclk_rise,
    output logic sclk_fall
);

    localparam int CW = $clog2(CLK_DIV + 1);

    logic [CW-1:0] cnt;
    logic          tick;

    assign tick      = en && (cnt == CW'(CLK_DIV - 1));
    assign sclk_rise = tick && !sclk;
    assign sclk_fall = tick && sclk;

    // NOTE: registered state is always written with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst || !en) begin
            cnt  <= '0;
            sclk <= 1'b0;
        end else if (tick) begin
            cnt  <= '0;
            sclk <= ~sclk;
        end else begin
            cnt  <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/tc_pl_cap_gain_spi_tx.sv
// Write-only SPI mode-0 transmitter: frames a burst of bytes under one csn
// assertion, double-buffered through a single holding register.
module tc_pl_cap_gain_spi_tx
    import tc_pl_cap_spi_pkg::*;
#(
    parameter int SPI0_0   = DEF_SPI0_0,
    parameter int CLK_DIV  = DEF_CLK_DIV,
    parameter int CS_SETUP = DEF_CS_SETUP,
    parameter int CS_HOLD  = DEF_CS_HOLD,
    parameter int CS_GAP   = DEF_CS_GAP
) (
    input  logic                    clk,
    input  logic                    rst,
    tc_pl_cap_gain_spi_tx_if.slave  stx,
    output logic                    spi_csn,
    output logic                    spi_sclk,
    output logic                    spi_mosi
);

    localparam int TW = $clog2(max3(CS_SETUP, CS_HOLD, CS_GAP) + 1);
    localparam int BW = $clog2(SPI0_0);

    spi_state_t        state, state_nxt;
    logic [TW-1:0]     tmr;
    logic [BW-1:0]     bit_cnt;
    logic [SPI0_0-1:0] shreg;
    logic [SPI0_0-1:0] nbuf;
    logic [SPI0_0-1:0] nxt_byte;
    logic              nbuf_vld;
    logic              csn_q, idle_q, dreq_q;
    logic              sclk_fall, sclk_rise_unused;
    logic              start, byte_end, reload, buf_take, shift_bit;

    tc_pl_cap_spi_clkgen #(
        .CLK_DIV (CLK_DIV)
    ) u_clkgen (
        .clk       (clk),
        .rst       (rst),
        .en        (state == SHIFT),
        .sclk      (spi_sclk),
        .sclk_rise (sclk_rise_unused),
        .sclk_fall (sclk_fall)
    );

    // A byte ends on its last falling edge; the next byte (buffered or
    // arriving that very cycle) is loaded there so sclk runs without a gap.
    assign start     = (state == IDLE) && stx.stx_valid;
    assign byte_end  = (state == SHIFT) && sclk_fall && (bit_cnt == BW'(SPI0_0 - 1));
    assign reload    = byte_end && (nbuf_vld || stx.stx_valid);
    assign shift_bit = (state == SHIFT) && sclk_fall;
    assign nxt_byte  = nbuf_vld ? nbuf : stx.stx_data;
    assign buf_take  = stx.stx_valid && !nbuf_vld &&
                       ((state == SETUP) || ((state == SHIFT) && !byte_end));

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // NOTE: state_nxt is defaulted first so no path through the case infers a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (stx.stx_valid)               state_nxt = SETUP;
            SETUP:   if (tmr == TW'(CS_SETUP - 1))    state_nxt = SHIFT;
            SHIFT:   if (byte_end && !reload)         state_nxt = HOLD;
            HOLD:    if (tmr == TW'(CS_HOLD - 1))     state_nxt = GAP;
            GAP:     if (tmr == TW'(CS_GAP - 1))      state_nxt = IDLE;
            default:                                  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            tmr      <= '0;
            bit_cnt  <= '0;
            nbuf_vld <= 1'b0;
            shreg    <= '0;
            csn_q    <= 1'b1;
            idle_q   <= 1'b1;
            dreq_q   <= 1'b0;
        end else begin
            if (state_nxt != state || state == IDLE || state == SHIFT) tmr <= '0;
            else                                                       tmr <= tmr + 1'b1;

            if (state != SHIFT)  bit_cnt <= '0;
            else if (byte_end)   bit_cnt <= '0;
            else if (sclk_fall)  bit_cnt <= bit_cnt + 1'b1;

            if (byte_end && nbuf_vld) nbuf_vld <= 1'b0;
            else if (buf_take)        nbuf_vld <= 1'b1;

            // The final shift of an unreloaded byte leaves shreg zero, idling mosi low.
            if (start)          shreg <= stx.stx_data;
            else if (reload)    shreg <= nxt_byte;
            else if (shift_bit) shreg <= {shreg[SPI0_0-2:0], 1'b0};

            if (start)                                  csn_q <= 1'b0;
            else if (state == HOLD && state_nxt == GAP) csn_q <= 1'b1;

            if (start)                                   idle_q <= 1'b0;
            else if (state == GAP && state_nxt == IDLE)  idle_q <= 1'b1;

            dreq_q <= start || reload;
        end
    end

    // NOTE: the holding buffer has no reset; nbuf_vld gates every read of it.
    always_ff @(posedge clk) begin
        if (buf_take) nbuf <= stx.stx_data;
    end

    assign spi_csn      = csn_q;
    assign spi_mosi     = shreg[SPI0_0-1];
    assign stx.stx_idle = idle_q;
    assign stx.stx_dreq = dreq_q;

endmodule

// File: tb/tb_tc_pl_cap_gain_spi_tx.sv
// Scoreboard bench for tc_pl_cap_gain_spi_tx: directed bursts push expected
// frames; a monitor reassembles each csn frame from the pins and compares.
module tb_tc_pl_cap_gain_spi_tx;

    localparam int W      = 8;
    localparam int T_SET  = 2;
    localparam int T_HOLD = 2;
    localparam int T_GAP  = 4;

    typedef struct {
        int          nbits;
        logic [31:0] data;
        int          low;
        int          dreqs;
        int          gap;
    } frame_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic sel = 1'b0;
    int   checks = 0;
    int   errors = 0;
    frame_t exp_q[$];

    always #5 clk = ~clk;

    tc_pl_cap_gain_spi_tx_if #(.SPI0_0(W)) if_a ();
    tc_pl_cap_gain_spi_tx_if #(.SPI0_0(W)) if_b ();

    logic csn_a, sclk_a, mosi_a, csn_b, sclk_b, mosi_b;
    logic m_csn, m_sclk, m_mosi, m_idle, m_dreq;

    tc_pl_cap_gain_spi_tx #(
        .SPI0_0(W), .CLK_DIV(2), .CS_SETUP(T_SET), .CS_HOLD(T_HOLD), .CS_GAP(T_GAP)
    ) dut_a (
        .clk(clk), .rst(rst), .stx(if_a),
        .spi_csn(csn_a), .spi_sclk(sclk_a), .spi_mosi(mosi_a)
    );

    tc_pl_cap_gain_spi_tx #(
        .SPI0_0(W), .CLK_DIV(1), .CS_SETUP(T_SET), .CS_HOLD(T_HOLD), .CS_GAP(T_GAP)
    ) dut_b (
        .clk(clk), .rst(rst), .stx(if_b),
        .spi_csn(csn_b), .spi_sclk(sclk_b), .spi_mosi(mosi_b)
    );

    assign m_csn  = sel ? csn_b  : csn_a;
    assign m_sclk = sel ? sclk_b : sclk_a;
    assign m_mosi = sel ? mosi_b : mosi_a;
    assign m_idle = sel ? if_b.stx_idle : if_a.stx_idle;
    assign m_dreq = sel ? if_b.stx_dreq : if_a.stx_dreq;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [W-1:0] d);
        if (sel) begin
            if_b.stx_valid = v;
            if_b.stx_data  = d;
        end else begin
            if_a.stx_valid = v;
            if_a.stx_data  = d;
        end
    endtask

    task automatic send(input logic [W-1:0] d);
        drive(1'b1, d);
        tick();
        drive(1'b0, '0);
    endtask

    task automatic expect_frame(input int nbits, input logic [31:0] data, input int low, input int dreqs);
        frame_t f;
        f.nbits = nbits;
        f.data  = data;
        f.low   = low;
        f.dreqs = dreqs;
        f.gap   = T_GAP;
        exp_q.push_back(f);
    endtask

    task automatic wait_dreq();
        int n = 0;
        while (!m_dreq && n < 200) begin
            tick();
            n++;
        end
        if (!m_dreq) begin
            checks++;
            errors++;
            $display("FAIL wait_dreq: no stx_dreq within 200 cycles");
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!m_idle && n < 400) begin
            tick();
            n++;
        end
        if (!m_idle) begin
            checks++;
            errors++;
            $display("FAIL wait_idle: stx_idle not back within 400 cycles");
        end
        repeat (3) tick();
    endtask

    // Frame monitor: counts csn-low cycles, samples mosi on sclk rises, counts
    // dreq pulses, then measures csn-high cycles until stx_idle returns.
    initial begin : monitor
        int          low, nbits, dreqs, gap;
        logic [31:0] bits;
        logic        in_frame, prev_sclk;
        frame_t      e;
        low = 0; nbits = 0; dreqs = 0; gap = 0; bits = '0;
        in_frame = 1'b0; prev_sclk = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                in_frame = 1'b0;
                low = 0; nbits = 0; dreqs = 0; bits = '0;
            end else if (m_csn == 1'b0) begin
                in_frame = 1'b1;
                low++;
                if (m_sclk && !prev_sclk) begin
                    bits = {bits[30:0], m_mosi};
                    nbits++;
                end
                if (m_dreq) dreqs++;
            end else if (in_frame) begin
                gap = 1;
                while (!m_idle && gap < 64) begin
                    @(negedge clk);
                    if (m_dreq) dreqs++;
                    if (!m_idle) gap++;
                end
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL frame_unexpected: got %0d bits data %0h, expected no frame", nbits, bits);
                end else begin
                    e = exp_q.pop_front();
                    check("frame_bits",     nbits, e.nbits);
                    check("frame_data",     bits,  e.data);
                    check("csn_low_cycles", low,   e.low);
                    check("dreq_pulses",    dreqs, e.dreqs);
                    check("idle_gap",       gap,   e.gap);
                end
                in_frame = 1'b0;
                low = 0; nbits = 0; dreqs = 0; bits = '0;
            end
            prev_sclk = m_sclk;
        end
    end

    initial begin : stimulus
        if_a.stx_valid = 1'b0; if_a.stx_data = '0;
        if_b.stx_valid = 1'b0; if_b.stx_data = '0;
        rst = 1'b0;
        repeat (3) tick();
        check("rst_csn",  csn_a, 1);
        check("rst_sclk", sclk_a, 0);
        check("rst_mosi", mosi_a, 0);
        check("rst_idle", if_a.stx_idle, 1);
        check("rst_dreq", if_a.stx_dreq, 0);
        rst = 1'b1;
        tick();

        // Single byte, nothing queued behind it.
        expect_frame(8, 32'h0000_00A5, 36, 1);
        send(8'hA5);
        wait_idle();

        // Three bytes, each offered one cycle after its dreq.
        expect_frame(24, 32'h0012_3456, 100, 3);
        send(8'h12);
        wait_dreq(); tick(); send(8'h34);
        wait_dreq(); tick(); send(8'h56);
        wait_idle();

        // Second byte lands exactly on the byte-end cycle (edge 34).
        expect_frame(16, 32'h0000_817E, 68, 2);
        send(8'h81);
        repeat (33) tick();
        send(8'h7E);
        wait_idle();

        // Second byte one cycle late: dropped, frame closes after one byte.
        expect_frame(8, 32'h0000_003C, 36, 1);
        send(8'h3C);
        repeat (34) tick();
        send(8'h77);
        wait_idle();

        // Two offers while the holding buffer fills: the second is dropped.
        expect_frame(16, 32'h0000_C311, 68, 2);
        send(8'hC3);
        send(8'h11);
        send(8'h22);
        wait_idle();

        // Reset during the second bit aborts the frame cleanly.
        send(8'hF0);
        repeat (8) tick();
        rst = 1'b0;
        tick();
        check("abort_csn",  csn_a, 1);
        check("abort_sclk", sclk_a, 0);
        check("abort_mosi", mosi_a, 0);
        check("abort_idle", if_a.stx_idle, 1);
        check("abort_dreq", if_a.stx_dreq, 0);
        rst = 1'b1;
        tick();
        expect_frame(8, 32'h0000_005A, 36, 1);
        send(8'h5A);
        wait_idle();

        // Fastest divider: sclk period of two clk cycles.
        sel = 1'b1;
        tick();
        expect_frame(8, 32'h0000_0069, 20, 1);
        send(8'h69);
        wait_idle();
        sel = 1'b0;

        repeat (5) tick();
        check("frames_outstanding", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
